enc_bundler_8: RTL and testbench

Bundling stage of the encoder, directly downstream of the 8-wide binder pack. Each accepted beat carries `FEATURES_PER_CC` shifted (bound) hypervectors. Over one sample, the block accumulates a per-dimension count of set bits across all `NUM_FEATURES` features. It then thresholds the counts into a single sparse encoded hypervector for the classifier/similarity stage.

---
 rtl/enc_bundler_8_if.sv | 25 ++
 rtl/enc_bundler_8.sv | 76 +++++++
 tb/tb_enc_bundler_8.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/enc_bundler_8_if.sv
// enc_bundler_8_if: sample control, bound-hypervector beat and encoded result bus of the bundler
//   master (upstream/driver): start_bundling, shifted_valid, shifted_hv[dim][feature], threshold
//   slave  (bundler)        : busy, done, encoded_hv
interface enc_bundler_8_if #(
    parameter int HV_DIM          = 1024,
    parameter int FEATURES_PER_CC = 8,
    parameter int NUM_FEATURES    = 512,
    parameter int CNT_W           = $clog2(NUM_FEATURES + 1)
);
    logic                                   start_bundling;
    logic                                   shifted_valid;
    logic [HV_DIM-1:0][0:FEATURES_PER_CC-1] shifted_hv;
    logic [CNT_W-1:0]                       threshold;
    logic                                   busy;
    logic                                   done;
    logic [HV_DIM-1:0]                      encoded_hv;
    modport master(
        output start_bundling, shifted_valid, shifted_hv, threshold,
        input  busy, done, encoded_hv
    );
    modport slave(
        input  start_bundling, shifted_valid, shifted_hv, threshold,
        output busy, done, encoded_hv
    );
endinterface

// File: rtl/enc_bundler_8.sv
// enc_bundler_8: accumulates per-dimension set-bit counts over one sample and thresholds them into encoded_hv
//   clk  : rising-edge clock
//   nrst : asynchronous active-low reset
//   bus  : enc_bundler_8_if.slave (start/valid/beat/threshold in, busy/done/encoded_hv out)
module enc_bundler_8 #(
    parameter int HV_DIM          = 1024,
    parameter int FEATURES_PER_CC = 8,
    parameter int NUM_FEATURES    = 512,
    localparam int GROUPS         = NUM_FEATURES / FEATURES_PER_CC,
    localparam int CNT_W          = $clog2(NUM_FEATURES + 1),
    localparam int GW             = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input logic             clk,
    input logic             nrst,
    enc_bundler_8_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, THRESH} state_t;
    state_t            state_q, state_d;
    logic [GW-1:0]     group_q, group_d;
    logic [CNT_W-1:0]  cnt_q [HV_DIM];
    logic [CNT_W-1:0]  cnt_d [HV_DIM];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HV_DIM-1:0] enc_q, enc_d;
    always_comb begin
        state_d = state_q;
        group_d = group_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start_bundling) begin
                for (int d = 0; d < HV_DIM; d++) cnt_d[d] = '0;
                group_d = '0;
                state_d = ACCUM;
            end
            ACCUM: if (bus.start_bundling) begin
                // restart wins over a concurrent beat, which is dropped
                for (int d = 0; d < HV_DIM; d++) cnt_d[d] = '0;
                group_d = '0;
            end else if (bus.shifted_valid) begin
                for (int d = 0; d < HV_DIM; d++)
                    cnt_d[d] = cnt_q[d] + CNT_W'($countones(bus.shifted_hv[d]));
                group_d = group_q + GW'(1);
                state_d = (group_q == GW'(GROUPS - 1)) ? THRESH : ACCUM;
            end
            THRESH: begin
                for (int d = 0; d < HV_DIM; d++) enc_d[d] = (cnt_q[d] >= bus.threshold);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            group_q <= '0;
            for (int d = 0; d < HV_DIM; d++) cnt_q[d] <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
        end
    end
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.encoded_hv = enc_q;
endmodule

// File: tb/tb_enc_bundler_8.sv
// tb_enc_bundler_8: randomized self-checking bench against a per-dimension count reference model
module tb_enc_bundler_8;
    localparam int HV = 1024;
    localparam int F  = 8;
    localparam int NF = 512;
    localparam int G  = NF / F;
    localparam int CW = $clog2(NF + 1);
    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    enc_bundler_8_if #(.HV_DIM(HV), .FEATURES_PER_CC(F), .NUM_FEATURES(NF)) bus ();
    enc_bundler_8 #(.HV_DIM(HV), .FEATURES_PER_CC(F), .NUM_FEATURES(NF)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );
    task automatic chk(input string tag, input logic [HV-1:0] got, input logic [HV-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (low 128 bits; ones got=%0d exp=%0d)",
                     tag, got[127:0], exp[127:0], $countones(got), $countones(exp));
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // 0: zeros, 1: ones, 2: bit5 from feature 0 and bit7 from features 0..2, 3: random
    function automatic logic [HV-1:0][0:F-1] mk_beat(input int mode);
        logic [HV-1:0][0:F-1] b;
        logic [HV*F-1:0]      r;
        b = '0;
        if (mode == 1) b = '1;
        if (mode == 2) begin
            b[5][0] = 1'b1;
            for (int f = 0; f < 3; f++) b[7][f] = 1'b1;
        end
        if (mode == 3) begin
            for (int w = 0; w < HV * F / 32; w++) r[w*32 +: 32] = $urandom;
            b = r;
        end
        return b;
    endfunction
    // stall: 0 none, 1 before every beat, 2 random; pre: junk beats before a restart
    task automatic run(input string tag, input int mode, input int thr, input int stall,
                       input int pre, input bit thr_start, input bit back);
        int                   cnt [HV];
        int                   edges;
        int                   stalls;
        bit                   got_done;
        logic [HV-1:0]        exp;
        logic [HV-1:0][0:F-1] b;
        bus.threshold = CW'(thr);
        if (pre > 0) begin
            bus.start_bundling = 1'b1;
            bus.shifted_valid  = 1'b0;
            tick;
            bus.start_bundling = 1'b0;
            for (int i = 0; i < pre; i++) begin
                bus.shifted_valid = 1'b1;
                bus.shifted_hv    = mk_beat(3);
                tick;
            end
        end
        foreach (cnt[d]) cnt[d] = 0;
        bus.start_bundling = 1'b1;
        bus.shifted_valid  = 1'b1;
        bus.shifted_hv     = mk_beat(3);
        tick;
        bus.start_bundling = 1'b0;
        edges  = 1;
        stalls = 0;
        chk({tag, " busy_accum"}, HV'(bus.busy), HV'(1));
        chk({tag, " done_accum"}, HV'(bus.done), HV'(0));
        for (int g = 0; g < G; g++) begin
            if (stall == 1 || (stall == 2 && $urandom_range(3) == 0)) begin
                bus.shifted_valid = 1'b0;
                bus.shifted_hv    = mk_beat(3);
                tick;
                edges++;
                stalls++;
            end
            b = mk_beat(mode);
            bus.shifted_valid = 1'b1;
            bus.shifted_hv    = b;
            tick;
            edges++;
            for (int d = 0; d < HV; d++) cnt[d] += $countones(b[d]);
        end
        bus.shifted_valid  = 1'b1;
        bus.shifted_hv     = mk_beat(1);
        bus.start_bundling = thr_start;
        got_done = 1'b0;
        for (int i = 0; i < 8 && !got_done; i++) begin
            tick;
            edges++;
            bus.start_bundling = 1'b0;
            got_done = bus.done;
        end
        bus.shifted_valid = 1'b0;
        for (int d = 0; d < HV; d++) exp[d] = (cnt[d] >= thr);
        chk({tag, " latency"}, HV'(edges), HV'(G + 2 + stalls));
        chk({tag, " done"}, HV'(got_done), HV'(1));
        chk({tag, " busy_done"}, HV'(bus.busy), HV'(0));
        chk({tag, " encoded"}, bus.encoded_hv, exp);
        if (!back) begin
            tick;
            chk({tag, " done_pulse"}, HV'(bus.done), HV'(0));
            chk({tag, " hold"}, bus.encoded_hv, exp);
        end
    endtask
    initial begin
        logic [HV-1:0] bits57;
        bus.start_bundling = 1'b0;
        bus.shifted_valid  = 1'b0;
        bus.shifted_hv     = '0;
        bus.threshold      = '0;
        repeat (3) tick;
        chk("rst busy", HV'(bus.busy), HV'(0));
        chk("rst done", HV'(bus.done), HV'(0));
        chk("rst enc", bus.encoded_hv, '0);
        nrst = 1'b1;
        tick;
        chk("post_rst busy", HV'(bus.busy), HV'(0));
        chk("post_rst enc", bus.encoded_hv, '0);
        run("zeros_t1", 0, 1, 0, 0, 0, 0);
        run("ones_t512", 1, 512, 0, 0, 0, 0);
        run("ones_t513", 1, 513, 0, 0, 0, 0);
        bits57 = '0;
        bits57[7] = 1'b1;
        run("pat_t65", 2, 65, 0, 0, 0, 0);
        chk("pat_t65 bit7_only", bus.encoded_hv, bits57);
        bits57[5] = 1'b1;
        run("pat_t64", 2, 64, 0, 0, 0, 0);
        chk("pat_t64 bits5_7", bus.encoded_hv, bits57);
        run("pat_t0", 2, 0, 0, 0, 0, 0);
        run("pat_stall", 2, 64, 1, 0, 0, 0);
        chk("pat_stall bits5_7", bus.encoded_hv, bits57);
        run("restart", 3, $urandom_range(276, 236), 0, 30, 0, 0);
        run("thr_start", 3, $urandom_range(276, 236), 2, 0, 1, 1);
        run("back2back", 3, $urandom_range(276, 236), 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) run("rand", 3, $urandom_range(290, 220), 2, 0, 0, k != 2);
        run("ones_pre_rst", 1, 0, 0, 0, 0, 0);
        bus.start_bundling = 1'b1;
        tick;
        bus.start_bundling = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.shifted_valid = 1'b1;
            bus.shifted_hv    = mk_beat(3);
            tick;
        end
        #2 nrst = 1'b0;
        #1;
        chk("async_rst busy", HV'(bus.busy), HV'(0));
        chk("async_rst done", HV'(bus.done), HV'(0));
        chk("async_rst enc", bus.encoded_hv, '0);
        bus.shifted_valid = 1'b0;
        tick;
        nrst = 1'b1;
        tick;
        run("after_rst", 3, $urandom_range(276, 236), 2, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
